// File: rtl/fizzbuzz_stream.sv
// -----------------------------------------------------------------------------
// fizzbuzz_stream
//
// Streams the numbers 1..g_length on a valid/ready interface. Each number
// carries two divisibility flags against run-time divisors latched at start.
// The block runs one-shot or wraps continuously, honours backpressure, can be
// aborted, and pulses o_done when a one-shot sequence completes.
//
// Divisibility uses per-divisor residue counters instead of dividers.
//
// Ports:
//   i_clk      clock, rising edge
//   i_rst      synchronous active-high reset
//   i_start    start request (IDLE only)
//   i_stop     abort request (RUN only)
//   i_wrap     1 = continuous, 0 = one-shot (sampled with i_start)
//   i_div_a    "fizz" divisor (sampled with i_start)
//   i_div_b    "buzz" divisor (sampled with i_start)
//   o_valid    output element valid
//   i_ready    downstream ready
//   o_number   current number 1..g_length
//   o_is_fizz  o_number is a multiple of latched div_a
//   o_is_buzz  o_number is a multiple of latched div_b
//   o_busy     registered, high while in RUN
//   o_done     one-cycle pulse on one-shot completion
// -----------------------------------------------------------------------------
module fizzbuzz_stream #(
  parameter  int g_length = 50,
  parameter  int g_div_w  = 8,
  localparam int g_num_w  = $clog2(g_length + 1)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic               i_stop,
  input  logic               i_wrap,
  input  logic [g_div_w-1:0] i_div_a,
  input  logic [g_div_w-1:0] i_div_b,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [g_num_w-1:0] o_number,
  output logic               o_is_fizz,
  output logic               o_is_buzz,
  output logic               o_busy,
  output logic               o_done
);

  localparam logic [g_num_w-1:0] c_last    = g_num_w'(g_length);
  localparam logic [g_num_w-1:0] c_num_one = g_num_w'(1);
  localparam logic [g_div_w-1:0] c_res_one = g_div_w'(1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [g_num_w-1:0]   number_q, number_d;
  logic                 valid_q, valid_d;
  logic                 done_q, done_d;
  logic                 busy_q, busy_d;
  logic                 wrap_q, wrap_d;

  // Residue-channel control, shared by both divisor channels.
  logic                 div_latch;   // capture divisors from the inputs
  logic                 res_load;    // number 1 is being loaded
  logic                 res_step;    // number advances by one
  logic                 xfer;

  logic [1:0][g_div_w-1:0] div_in;
  logic [1:0]              flag;

  assign div_in = {i_div_b, i_div_a};
  assign xfer   = valid_q & i_ready;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    number_d  = number_q;
    valid_d   = valid_q;
    done_d    = 1'b0;
    wrap_d    = wrap_q;
    div_latch = 1'b0;
    res_load  = 1'b0;
    res_step  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        valid_d = 1'b0;
        if (i_start) begin
          div_latch = 1'b1;
          res_load  = 1'b1;
          wrap_d    = i_wrap;
          number_d  = c_num_one;
          valid_d   = 1'b1;
          state_d   = ST_RUN;
        end
      end

      ST_RUN: begin
        // Abort wins over completion and wrap; a simultaneous handshake is
        // still a completed transfer from the consumer's point of view.
        if (i_stop) begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end else if (xfer) begin
          if (number_q == c_last) begin
            if (wrap_q) begin
              number_d = c_num_one;
              res_load = 1'b1;
            end else begin
              valid_d = 1'b0;
              done_d  = 1'b1;
              state_d = ST_IDLE;
            end
          end else begin
            number_d = number_q + c_num_one;
            res_step = 1'b1;
          end
        end
      end

      default: begin
        valid_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_RUN);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      number_q <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      number_q <= number_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      wrap_q   <= wrap_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Residue channels: channel 0 tracks div_a (fizz), channel 1 div_b (buzz).
  // The residue counts 1..div and reloads to 1 after reaching div, so it
  // equals div exactly on multiples. Divisor 1 keeps the residue pinned at 1,
  // giving a constant flag; divisor 0 is masked so a wrapping residue can
  // never match it.
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < 2; gi++) begin : g_res
    logic [g_div_w-1:0] div_q, div_d;
    logic [g_div_w-1:0] res_q, res_d;

    always_comb begin
      div_d = div_q;
      res_d = res_q;
      if (div_latch) begin
        div_d = div_in[gi];
      end
      if (res_load) begin
        res_d = c_res_one;
      end else if (res_step) begin
        res_d = (res_q == div_q) ? c_res_one : res_q + c_res_one;
      end
    end

    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        div_q <= '0;
        res_q <= '0;
      end else begin
        div_q <= div_d;
        res_q <= res_d;
      end
    end

    assign flag[gi] = (div_q != '0) && (res_q == div_q);
  end

  assign o_valid   = valid_q;
  assign o_number  = number_q;
  assign o_is_fizz = flag[0];
  assign o_is_buzz = flag[1];
  assign o_busy    = busy_q;
  assign o_done    = done_q;

endmodule

// File: tb/tb_fizzbuzz_stream.sv
// -----------------------------------------------------------------------------
// tb_fizzbuzz_stream
//
// Scoreboard bench for fizzbuzz_stream (g_length = 15). Expected elements are
// queued when a run is started and popped whenever the DUT completes a
// handshake. Inputs change 1 ns after the rising edge; outputs are sampled on
// the falling edge or 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_fizzbuzz_stream;

  localparam int c_len   = 15;
  localparam int c_div_w = 8;
  localparam int c_num_w = $clog2(c_len + 1);

  logic               clk = 1'b0;
  logic               i_rst;
  logic               i_start;
  logic               i_stop;
  logic               i_wrap;
  logic [c_div_w-1:0] i_div_a;
  logic [c_div_w-1:0] i_div_b;
  logic               i_ready;
  logic               o_valid;
  logic [c_num_w-1:0] o_number;
  logic               o_is_fizz;
  logic               o_is_buzz;
  logic               o_busy;
  logic               o_done;

  typedef struct {
    int num;
    int fz;
    int bz;
  } item_t;

  item_t sb[$];
  int    n_cmp    = 0;
  int    n_err    = 0;
  int    done_cnt = 0;

  always #5 clk = ~clk;

  fizzbuzz_stream #(
    .g_length (c_len),
    .g_div_w  (c_div_w)
  ) dut (
    .i_clk     (clk),
    .i_rst     (i_rst),
    .i_start   (i_start),
    .i_stop    (i_stop),
    .i_wrap    (i_wrap),
    .i_div_a   (i_div_a),
    .i_div_b   (i_div_b),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_number  (o_number),
    .o_is_fizz (o_is_fizz),
    .o_is_buzz (o_is_buzz),
    .o_busy    (o_busy),
    .o_done    (o_done)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int is_mult(input int n, input int d);
    return (d != 0 && (n % d) == 0) ? 1 : 0;
  endfunction

  // One clock cycle: monitor on the falling edge, return 1 ns after the
  // rising edge so the caller can drive the next cycle's inputs.
  task automatic tick();
    item_t e;
    @(negedge clk);
    if (o_done) done_cnt++;
    if (!i_rst && o_valid && i_ready) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", sb.size(), 1);
      end else begin
        e = sb.pop_front();
        $display("xfer num=%0d fizz=%0d buzz=%0d (exp %0d/%0d/%0d)",
                 o_number, o_is_fizz, o_is_buzz, e.num, e.fz, e.bz);
        chk("num", int'(o_number), e.num);
        chk("fizz", int'(o_is_fizz), e.fz);
        chk("buzz", int'(o_is_buzz), e.bz);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int a, input int b, input int w, input int cnt);
    item_t e;
    i_start = 1'b1;
    i_div_a = c_div_w'(a);
    i_div_b = c_div_w'(b);
    i_wrap  = w[0];
    for (int i = 0; i < cnt; i++) begin
      e.num = (i % c_len) + 1;
      e.fz  = is_mult(e.num, a);
      e.bz  = is_mult(e.num, b);
      sb.push_back(e);
    end
    tick();
    i_start = 1'b0;
    chk("lat_valid", int'(o_valid), 1);
    chk("lat_num", int'(o_number), 1);
    chk("lat_busy", int'(o_busy), 1);
  endtask

  task automatic drain(input int budget, output int cyc);
    cyc = 0;
    while (sb.size() > 0 && cyc < budget) begin
      tick();
      cyc++;
    end
    if (sb.size() > 0) chk("drain_timeout", sb.size(), 0);
  endtask

  task automatic wait_num(input int n, input int budget);
    int k = 0;
    while (int'(o_number) != n && k < budget) begin
      tick();
      k++;
    end
    if (int'(o_number) != n) chk("wait_num_timeout", int'(o_number), n);
  endtask

  task automatic finish_oneshot(input string tag, input int d0);
    tick();
    tick();
    chk({tag, "_done_cnt"}, done_cnt - d0, 1);
    chk({tag, "_busy"}, int'(o_busy), 0);
    chk({tag, "_valid"}, int'(o_valid), 0);
  endtask

  initial begin
    int c;
    int d0;

    i_rst   = 1'b1;
    i_start = 1'b0;
    i_stop  = 1'b0;
    i_wrap  = 1'b0;
    i_div_a = '0;
    i_div_b = '0;
    i_ready = 1'b0;
    repeat (3) tick();
    chk("rst_valid", int'(o_valid), 0);
    chk("rst_num", int'(o_number), 0);
    chk("rst_fizz", int'(o_is_fizz), 0);
    chk("rst_buzz", int'(o_is_buzz), 0);
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_done", int'(o_done), 0);
    i_rst = 1'b0;
    tick();

    // 1: one-shot 3/5 at full rate
    i_ready = 1'b1;
    d0 = done_cnt;
    do_start(3, 5, 0, c_len);
    drain(100, c);
    chk("t1_rate", c, c_len);
    finish_oneshot("t1", d0);

    // 2: stall on 7
    d0 = done_cnt;
    do_start(3, 5, 0, c_len);
    wait_num(7, 50);
    i_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t2_hold_num", int'(o_number), 7);
      chk("t2_hold_fizz", int'(o_is_fizz), 0);
      chk("t2_hold_valid", int'(o_valid), 1);
    end
    i_ready = 1'b1;
    tick();
    chk("t2_next", int'(o_number), 8);
    drain(100, c);
    finish_oneshot("t2", d0);

    // 3: divisor 0, divisor 1, divisor beyond the sequence length
    d0 = done_cnt;
    do_start(4, 0, 0, c_len);
    drain(100, c);
    finish_oneshot("t3a", d0);
    d0 = done_cnt;
    do_start(1, 20, 0, c_len);
    drain(100, c);
    finish_oneshot("t3b", d0);

    // 4: wrap mode for 40 transfers, then abort
    d0 = done_cnt;
    do_start(3, 5, 1, 40);
    drain(200, c);
    chk("t4_rate", c, 40);
    i_ready = 1'b0;
    i_stop  = 1'b1;
    tick();
    i_stop = 1'b0;
    chk("t4_valid", int'(o_valid), 0);
    chk("t4_busy", int'(o_busy), 0);
    chk("t4_done", int'(o_done), 0);
    tick();
    chk("t4_done_cnt", done_cnt - d0, 0);

    // 5: abort at 9 (handshake in the same cycle), restart with new divisors
    i_ready = 1'b1;
    d0 = done_cnt;
    do_start(3, 5, 0, c_len);
    wait_num(9, 50);
    i_stop = 1'b1;
    tick();
    i_stop = 1'b0;
    chk("t5_valid", int'(o_valid), 0);
    chk("t5_busy", int'(o_busy), 0);
    chk("t5_done", int'(o_done), 0);
    sb.delete();
    tick();
    chk("t5_done_cnt", done_cnt - d0, 0);
    d0 = done_cnt;
    do_start(2, 7, 0, c_len);
    drain(100, c);
    finish_oneshot("t5", d0);

    // 6: reset mid-stall at 11, with start and stop also asserted
    do_start(3, 5, 0, c_len);
    wait_num(11, 50);
    i_ready = 1'b0;
    tick();
    tick();
    i_rst   = 1'b1;
    i_start = 1'b1;
    i_stop  = 1'b1;
    tick();
    chk("t6_valid", int'(o_valid), 0);
    chk("t6_num", int'(o_number), 0);
    chk("t6_fizz", int'(o_is_fizz), 0);
    chk("t6_buzz", int'(o_is_buzz), 0);
    chk("t6_busy", int'(o_busy), 0);
    chk("t6_done", int'(o_done), 0);
    i_rst   = 1'b0;
    i_start = 1'b0;
    i_stop  = 1'b0;
    sb.delete();
    tick();
    chk("t6_idle_valid", int'(o_valid), 0);
    chk("t6_idle_busy", int'(o_busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
